imm_ext_pipe: RTL and testbench

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/imm_ext_core.sv | 40 ++++
 rtl/imm_ext_pipe.sv | 103 ++++++++++
 tb/tb_imm_ext_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: immediate-extension modes, ALU operations and decode control word.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IMM_SEXT  = 2'd0,
    IMM_ZEXT  = 2'd1,
    IMM_LUI   = 2'd2,
    IMM_SHAMT = 2'd3
  } imm_mode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    imm_mode_e imm_mode;
    alu_op_e   alu_op;
  } ctrl_t;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender; shared by the decode stage and imm_ext_pipe.
module imm_ext_core
  import cpu_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [IN_W-1:0]  in_imm,
  input  imm_mode_e        mode,
  output logic [OUT_W-1:0] ext_imm
);

  localparam int EXT_W = OUT_W - IN_W;

  generate
    if (OUT_W < IN_W) begin : g_bad_out_w
      $error("imm_ext_core: OUT_W must be >= IN_W");
    end
    if (SHAMT_W > IN_W) begin : g_bad_shamt_w
      $error("imm_ext_core: SHAMT_W must be <= IN_W");
    end
  endgenerate

  logic signed [IN_W-1:0] imm_s;
  assign imm_s = in_imm;

  // Sized casts extend according to operand signedness; LUI shifts by zero when widths match.
  always_comb begin
    ext_imm = '0;
    case (mode)
      IMM_SEXT:  ext_imm = OUT_W'(imm_s);
      IMM_ZEXT:  ext_imm = OUT_W'(in_imm);
      IMM_LUI:   ext_imm = OUT_W'(in_imm) << EXT_W;
      IMM_SHAMT: ext_imm = OUT_W'(in_imm[SHAMT_W-1:0]);
      default:   ext_imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extension followed by a 2-entry FIFO skid buffer holding {extended imm, tag}.
module imm_ext_pipe
  import cpu_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int ENT_W = OUT_W + TAG_W;

  logic [1:0]       count_q, count_d;
  logic [ENT_W-1:0] head_q, head_d;
  logic [ENT_W-1:0] tail_q, tail_d;
  logic [OUT_W-1:0] ext_imm;
  logic [ENT_W-1:0] new_entry;
  logic             push, pop;

  imm_ext_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .in_imm  (in_imm),
    .mode    (imm_mode_e'(in_mode)),
    .ext_imm (ext_imm)
  );

  assign new_entry = {ext_imm, in_tag};

  // Handshake signals derive only from registered count (plus rst), never from out_ready.
  assign in_ready  = (count_q < 2'd2) && !rst;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_d  = new_entry;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = new_entry;
          end else if (push) begin
            tail_d  = new_entry;
            count_d = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_d  = tail_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign out_imm = out_valid ? head_q[ENT_W-1:TAG_W] : '0;
  assign out_tag = out_valid ? head_q[TAG_W-1:0]     : '0;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed and randomized-handshake checks for imm_ext_pipe (32-bit and 16-bit output variants).
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;

  logic        in_ready, out_valid;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;

  logic        in_ready2, out_valid2;
  logic [15:0] out_imm2;
  logic [4:0]  out_tag2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .SHAMT_W(5), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag)
  );

  imm_ext_pipe #(.IN_W(16), .OUT_W(16), .SHAMT_W(5), .TAG_W(5)) dut16 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid2), .out_ready(out_ready), .out_imm(out_imm2), .out_tag(out_tag2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_imm = '0; in_mode = 2'd0; in_tag = '0;
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_imm !== 32'h0) begin bad++; $display("FAIL reset_out_imm got=%h exp=0", out_imm); end
    total++; if (out_tag !== 5'h0) begin bad++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_during_rst got=%b exp=0", in_ready); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready); end
    total++; if (in_ready2 !== 1'b1) begin bad++; $display("FAIL reset_in_ready16_after got=%b exp=1", in_ready2); end
  endtask

  task automatic test_modes();
    logic [31:0] exp32 [4];
    logic [15:0] exp16 [4];
    exp32[0] = 32'hFFFF8001; exp32[1] = 32'h00008001; exp32[2] = 32'h80010000; exp32[3] = 32'h00000001;
    exp16[0] = 16'h8001;     exp16[1] = 16'h8001;     exp16[2] = 16'h8001;     exp16[3] = 16'h0001;
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      in_valid = 1'b1; in_imm = 16'h8001; in_mode = 2'(m); in_tag = 5'(m + 1);
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mode%0d_valid got=%b exp=1", m, out_valid); end
      total++; if (out_imm !== exp32[m]) begin bad++; $display("FAIL mode%0d_imm32 got=%h exp=%h", m, out_imm, exp32[m]); end
      total++; if (out_imm2 !== exp16[m]) begin bad++; $display("FAIL mode%0d_imm16 got=%h exp=%h", m, out_imm2, exp16[m]); end
      total++; if (out_tag !== 5'(m + 1)) begin bad++; $display("FAIL mode%0d_tag got=%0d exp=%0d", m, out_tag, m + 1); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mode%0d_drained got=%b exp=0", m, out_valid); end
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0; in_mode = 2'd1;
    in_valid = 1'b1; in_imm = 16'h0011; in_tag = 5'd1;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after1 got=%b exp=1", in_ready); end
    in_imm = 16'h0022; in_tag = 5'd2;
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_after2 got=%b exp=0", in_ready); end
    in_imm = 16'h0033; in_tag = 5'd3;
    step(); step();
    total++; if (out_tag !== 5'd1) begin bad++; $display("FAIL bp_head_stable got=%0d exp=1", out_tag); end
    total++; if (out_imm !== 32'h11) begin bad++; $display("FAIL bp_head_imm got=%h exp=11", out_imm); end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_indep got=%b exp=0", in_ready); end
    step();
    total++; if (out_tag !== 5'd2) begin bad++; $display("FAIL bp_second_tag got=%0d exp=2", out_tag); end
    total++; if (out_imm !== 32'h22) begin bad++; $display("FAIL bp_second_imm got=%h exp=22", out_imm); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_tag3 got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_mode = 2'd1;
    in_valid = 1'b1; in_imm = 16'h0100; in_tag = 5'd0;
    step();
    for (int i = 1; i <= 8; i++) begin
      total++; if (out_valid !== 1'b1 || out_tag !== 5'(i - 1) || out_imm !== 32'(16'h0100 + i - 1)) begin
        bad++; $display("FAIL stream%0d got v=%b tag=%0d imm=%h exp v=1 tag=%0d imm=%h",
                        i, out_valid, out_tag, out_imm, i - 1, 32'(16'h0100 + i - 1));
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream%0d_ready got=%b exp=1", i, in_ready); end
      if (i < 8) begin
        in_imm = 16'(16'h0100 + i); in_tag = 5'(i);
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_mode = 2'd1; in_valid = 1'b1;
    in_imm = 16'h000A; in_tag = 5'd10; step();
    in_imm = 16'h000B; in_tag = 5'd11; step();
    flush = 1'b1; in_imm = 16'h000C; in_tag = 5'd12;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_full_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_full_ready got=%b exp=1", in_ready); end
    total++; if (out_imm !== 32'h0) begin bad++; $display("FAIL flush_full_imm got=%h exp=0", out_imm); end
    flush = 1'b1; in_valid = 1'b1; in_imm = 16'h000D; in_tag = 5'd13;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drops_input got=%b exp=0", out_valid); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_nothing_later got=%b exp=0", out_valid); end
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b0; in_mode = 2'd0; in_valid = 1'b1;
    in_imm = 16'h1234; in_tag = 5'd7; step();
    in_imm = 16'h5678; in_tag = 5'd8; step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    total++; if (out_imm !== 32'h0) begin bad++; $display("FAIL rstmid_imm got=%h exp=0", out_imm); end
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_imm = 16'h7FFF; in_mode = 2'd0; in_tag = 5'd5;
    step();
    in_valid = 1'b0;
    total++; if (out_imm !== 32'h00007FFF || out_tag !== 5'd5) begin
      bad++; $display("FAIL rstmid_new got imm=%h tag=%0d exp imm=00007fff tag=5", out_imm, out_tag);
    end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_stale got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] q32 [$];
    logic [15:0] q16 [$];
    logic [4:0]  qtag [$];
    logic [31:0] e32;
    logic [15:0] e16;
    logic [4:0]  tag_ctr;
    tag_ctr = '0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      in_tag    = tag_ctr;
      #1;
      total++; if (out_valid !== (q32.size() != 0) || out_valid2 !== out_valid) begin
        bad++; $display("FAIL rand_valid c=%0d got=%b/%b exp=%b", c, out_valid, out_valid2, q32.size() != 0);
      end
      if (out_valid && out_ready && q32.size() != 0) begin
        total++; if (out_imm !== q32[0] || out_tag !== qtag[0] || out_imm2 !== q16[0] || out_tag2 !== qtag[0]) begin
          bad++; $display("FAIL rand_data c=%0d got %h/%h tag %0d exp %h/%h tag %0d",
                          c, out_imm, out_imm2, out_tag, q32[0], q16[0], qtag[0]);
        end
        void'(q32.pop_front()); void'(q16.pop_front()); void'(qtag.pop_front());
      end
      if (in_valid && in_ready) begin
        case (in_mode)
          2'd0: e32 = {{16{in_imm[15]}}, in_imm};
          2'd1: e32 = {16'h0, in_imm};
          2'd2: e32 = {in_imm, 16'h0};
          default: e32 = {27'h0, in_imm[4:0]};
        endcase
        e16 = (in_mode == 2'd3) ? {11'h0, in_imm[4:0]} : in_imm;
        q32.push_back(e32); q16.push_back(e16); qtag.push_back(tag_ctr);
        tag_ctr = tag_ctr + 5'd1;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_final_empty got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_pressure();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
